// File: rtl/bit_decomp_if.sv
// bit_decomp_if: stream handshake bundle for bit_decomp (control, coefficient input, bit-plane output)
//   master drives start/in_valid/in_coeff/out_ready; slave (the block) drives the rest
interface bit_decomp_if #(
  parameter int K     = 40,
  parameter int LOG_N = 10,
  parameter int LOG_K = 6
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     in_coeff;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [LOG_K-1:0] out_plane;
  logic [LOG_N-1:0] out_index;
  logic             out_plane_last;
  logic             out_last;
  logic             done;
  modport master (
    output start, in_valid, in_coeff, out_ready,
    input  in_ready, out_valid, out_bit, out_plane, out_index, out_plane_last, out_last, done
  );
  modport slave (
    input  start, in_valid, in_coeff, out_ready,
    output in_ready, out_valid, out_bit, out_plane, out_index, out_plane_last, out_last, done
  );
endinterface

// File: rtl/bit_decomp.sv
// bit_decomp: loads N K-bit coefficients, then streams their bits plane-major (plane i of all j before plane i+1)
//   clk, reset (async, active-high); bus: start, in_valid/in_ready/in_coeff,
//   out_valid/out_ready/out_bit/out_plane/out_index/out_plane_last/out_last, done
module bit_decomp #(
  parameter int N     = 1024,
  parameter int K     = 40,
  parameter int LOG_N = 10,
  parameter int LOG_K = 6
) (
  input logic        clk,
  input logic        reset,
  bit_decomp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
  localparam logic [LOG_N-1:0] J_LAST = LOG_N'(N - 1);
  localparam logic [LOG_K-1:0] I_LAST = LOG_K'(K - 1);
  state_t           state, state_nx;
  logic [K-1:0]     mem [N];
  logic [K-1:0]     rd_word;
  logic [LOG_N-1:0] wr_cnt, rd_j, rd_idx;
  logic [LOG_K-1:0] rd_i, rd_pl;
  logic             rd_vld, iss_done, adv, issue, acc, fin, last_j;
  // Two-stage read pipeline (RAM word register, then output register) stalled as one unit
  assign adv          = !bus.out_valid || bus.out_ready;
  assign acc          = state == LOAD && bus.in_valid;
  assign issue        = state == EMIT && !iss_done && adv;
  assign fin          = state == EMIT && bus.out_valid && bus.out_ready && bus.out_last;
  assign last_j       = rd_j == J_LAST;
  assign bus.in_ready = state == LOAD;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && bus.start)  ? LOAD :
               (acc && wr_cnt == J_LAST)     ? EMIT :
               fin                           ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (acc)   mem[wr_cnt] <= bus.in_coeff;
    if (issue) rd_word     <= mem[rd_j];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt   <= '0;
      rd_i     <= '0;
      rd_j     <= '0;
      rd_pl    <= '0;
      rd_idx   <= '0;
      rd_vld   <= 1'b0;
      iss_done <= 1'b0;
    end else begin
      if (acc) wr_cnt <= wr_cnt == J_LAST ? '0 : wr_cnt + LOG_N'(1);
      if (issue) begin
        rd_j     <= last_j ? '0 : rd_j + LOG_N'(1);
        rd_i     <= !last_j ? rd_i : rd_i == I_LAST ? '0 : rd_i + LOG_K'(1);
        iss_done <= last_j && rd_i == I_LAST;
        rd_pl    <= rd_i;
        rd_idx   <= rd_j;
      end
      if (adv) rd_vld <= issue;
      if (fin) begin
        rd_i     <= '0;
        rd_j     <= '0;
        iss_done <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid      <= 1'b0;
      bus.out_bit        <= 1'b0;
      bus.out_plane      <= '0;
      bus.out_index      <= '0;
      bus.out_plane_last <= 1'b0;
      bus.out_last       <= 1'b0;
      bus.done           <= 1'b0;
    end else begin
      bus.done <= fin;
      if (adv) begin
        bus.out_valid      <= rd_vld;
        bus.out_bit        <= rd_vld && rd_word[rd_pl];
        bus.out_plane      <= rd_pl;
        bus.out_index      <= rd_idx;
        bus.out_plane_last <= rd_vld && rd_idx == J_LAST;
        bus.out_last       <= rd_vld && rd_idx == J_LAST && rd_pl == I_LAST;
      end
    end
  end
endmodule

// File: tb/tb_bit_decomp.sv
// tb_bit_decomp: directed checks of bit_decomp on a 4x3 instance and the default 1024x40 instance
module tb_bit_decomp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  bit_decomp_if #(.K(3), .LOG_N(2), .LOG_K(2)) s ();
  bit_decomp_if b ();
  bit_decomp #(.N(4), .K(3), .LOG_N(2), .LOG_K(2)) u_s (.clk(clk), .reset(reset), .bus(s.slave));
  bit_decomp u_b (.clk(clk), .reset(reset), .bus(b.slave));
  localparam logic [11:0] V_A = {3'd0, 3'd7, 3'd2, 3'd5};
  localparam logic [11:0] V_B = {3'd4, 3'd1, 3'd6, 3'd3};
  int nvec = 0;
  int nerr = 0;
  logic [39:0] bm [1024];
  logic [39:0] recon [1024];
  int n, cyc, bad, ordbad, rbad;
  logic seen;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic load_s(input logic [11:0] c, input bit do_start, input bit gaps);
    if (do_start) begin
      s.start = 1'b1;
      step;
      s.start = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        s.in_valid = 1'b0;
        step;
      end
      s.in_valid = 1'b1;
      s.in_coeff = c[j*3 +: 3];
      step;
    end
    s.in_valid = 1'b0;
  endtask
  task automatic run_s(input string tag, input bit bp, input bit pulse, input bit b2b, input logic [11:0] exp);
    logic [11:0] bits = '0;
    logic [11:0] pll = '0;
    logic [11:0] lst = '0;
    logic [6:0] prev = '0;
    logic [6:0] cur;
    logic hold = 1'b0;
    int k = 0;
    int c = 0;
    int unstable = 0;
    int obad = 0;
    while (k < 12 && c < 400) begin
      cur = {s.out_bit, s.out_plane, s.out_index, s.out_plane_last, s.out_last};
      if (hold && cur !== prev) unstable++;
      s.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s.start = pulse && k == 5;
      if (s.out_valid && s.out_ready) begin
        bits[k] = s.out_bit;
        pll[k]  = s.out_plane_last;
        lst[k]  = s.out_last;
        if (s.out_plane != 2'(k / 4) || s.out_index != 2'(k % 4)) obad++;
        k++;
      end
      hold = s.out_valid && !s.out_ready;
      prev = cur;
      step;
      c++;
    end
    s.start = 1'b0;
    s.out_ready = 1'b1;
    check({tag, "_count"}, k, 12);
    check({tag, "_bits"}, bits, exp);
    check({tag, "_plane_last"}, pll, 12'h888);
    check({tag, "_last"}, lst, 12'h800);
    check({tag, "_order"}, obad, 0);
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_done_hi"}, {s.done, s.out_valid}, 2'b10);
    if (b2b) s.start = 1'b1;
    step;
    s.start = 1'b0;
    check({tag, "_done_lo"}, s.done, 0);
    check({tag, "_in_ready_after"}, s.in_ready, b2b);
  endtask
  initial begin
    s.start = 0; s.in_valid = 0; s.in_coeff = '0; s.out_ready = 1;
    b.start = 0; b.in_valid = 0; b.in_coeff = '0; b.out_ready = 1;
    step;
    step;
    check("reset_outs_s", {s.in_ready, s.out_valid, s.done, s.out_bit, s.out_plane, s.out_index, s.out_plane_last, s.out_last}, 0);
    check("reset_outs_b", {b.in_ready, b.out_valid, b.done, b.out_bit, b.out_plane, b.out_index, b.out_plane_last, b.out_last}, 0);
    reset = 1'b0;
    step;
    s.start = 1'b1;
    step;
    s.start = 1'b0;
    check("load_in_ready", s.in_ready, 1);
    s.in_valid = 1'b1;
    s.in_coeff = 3'd5;
    step;
    step;
    s.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("rst_async_load", {s.in_ready, s.out_valid, s.done}, 0);
    step;
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      step;
      seen |= s.in_ready;
    end
    check("idle_no_start", seen, 0);
    load_s(V_A, 1, 0);
    check("lat_e0", s.out_valid, 0);
    step;
    check("lat_e1", s.out_valid, 0);
    step;
    check("lat_e2", s.out_valid, 1);
    run_s("frame", 0, 0, 0, 12'h565);
    load_s(V_A, 1, 1);
    run_s("bp", 1, 0, 0, 12'h565);
    load_s(12'hFFF, 1, 0);
    run_s("ones", 0, 0, 0, 12'hFFF);
    load_s(12'h000, 1, 0);
    run_s("zeros", 1, 0, 0, 12'h000);
    load_s(V_A, 1, 0);
    run_s("pulse", 0, 1, 1, 12'h565);
    load_s(V_B, 0, 0);
    run_s("b2b", 0, 0, 0, 12'hA35);
    load_s(V_A, 1, 0);
    cyc = 0;
    while (!(s.out_valid && s.out_plane == 2'd2) && cyc < 100) begin
      step;
      cyc++;
    end
    check("reach_plane2", {s.out_valid, s.out_plane}, 3'b110);
    #2 reset = 1'b1;
    #1 check("rst_async_emit", {s.out_valid, s.done, s.in_ready, s.out_plane}, 0);
    step;
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      step;
      seen |= s.done | s.out_valid | s.in_ready;
    end
    check("abort_quiet", seen, 0);
    load_s(V_B, 1, 0);
    run_s("recover", 1, 0, 0, 12'hA35);
    for (int j = 0; j < 1024; j++) begin
      bm[j] = 40'(64'(j) * 64'h9E3779B1);
      recon[j] = '0;
    end
    b.start = 1'b1;
    step;
    b.start = 1'b0;
    for (int j = 0; j < 1024; j++) begin
      b.in_valid = 1'b1;
      b.in_coeff = bm[j];
      step;
    end
    b.in_valid = 1'b0;
    n = 0; cyc = 0; bad = 0; ordbad = 0; rbad = 0;
    while (n < 40960 && cyc < 45000) begin
      if (b.out_valid) begin
        if (b.out_bit !== bm[b.out_index][b.out_plane]) bad++;
        if (b.out_plane != 6'(n / 1024) || b.out_index != 10'(n % 1024)) ordbad++;
        recon[b.out_index][b.out_plane] = b.out_bit;
        n++;
      end
      step;
      cyc++;
    end
    for (int j = 0; j < 1024; j++) if (recon[j] !== bm[j]) rbad++;
    check("big_count", n, 40960);
    check("big_bits", bad, 0);
    check("big_order", ordbad, 0);
    check("big_recon", rbad, 0);
    check("big_done", {b.done, b.out_valid}, 2'b10);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
